// File: rtl/keypad_divider_display_if.sv
// Board-side bundle: keypad matrix, seven-segment display and debug taps.
// master = the divider design, slave = the board / keypad model.
interface keypad_divider_display_if;
  logic [3:0] fil;
  logic [3:0] col;
  logic [3:0] anodo;
  logic [6:0] seven;
  logic [7:0] A_bin_debug;
  logic [7:0] B_bin_debug;
  logic [6:0] Q_debug;
  logic [6:0] R_debug;
  logic       div_done_debug;

  modport master (
    input  fil,
    output col, anodo, seven, A_bin_debug, B_bin_debug, Q_debug, R_debug, div_done_debug
  );

  modport slave (
    output fil,
    input  col, anodo, seven, A_bin_debug, B_bin_debug, Q_debug, R_debug, div_done_debug
  );
endinterface

// File: rtl/keypad_divider_display.sv
// Keypad-driven two-digit divider: matrix scan + debounce, entry FSM,
// 7-step restoring divider and a 4-digit multiplexed seven-segment driver.
module keypad_divider_display #(
  parameter int SCAN_DIV     = 50000,
  parameter int DEBOUNCE_CNT = 4,
  parameter int REFRESH_DIV  = 50000
) (
  input logic clk,
  input logic rst,
  keypad_divider_display_if.master bus
);
  localparam int SW = (SCAN_DIV    > 1) ? $clog2(SCAN_DIV)    : 1;
  localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int DW = $clog2(DEBOUNCE_CNT + 1) + 1;
  localparam logic [DW-1:0] DEB      = DW'(DEBOUNCE_CNT);
  localparam logic [3:0]    KEY_STAR = 4'd14;
  localparam logic [3:0]    C_E      = 4'd14;
  localparam logic [3:0]    C_BLANK  = 4'd15;

  typedef enum logic [1:0] {ENTER_A, ENTER_B, DIVIDE, SHOW} state_t;

  // Key codes: 0-9 digits, 10-13 = A-D, 14 = '*', 15 = '#'
  function automatic logic [3:0] key_code(input logic [1:0] row, input logic [1:0] c);
    case ({row, c})
      4'h0: key_code = 4'd1;  4'h1: key_code = 4'd2;  4'h2: key_code = 4'd3;  4'h3: key_code = 4'd10;
      4'h4: key_code = 4'd4;  4'h5: key_code = 4'd5;  4'h6: key_code = 4'd6;  4'h7: key_code = 4'd11;
      4'h8: key_code = 4'd7;  4'h9: key_code = 4'd8;  4'hA: key_code = 4'd9;  4'hB: key_code = 4'd12;
      4'hC: key_code = 4'd14; 4'hD: key_code = 4'd0;  4'hE: key_code = 4'd15; default: key_code = 4'd13;
    endcase
  endfunction

  function automatic logic [6:0] seg(input logic [3:0] d);
    case (d)
      4'd0: seg = 7'h40; 4'd1: seg = 7'h79; 4'd2: seg = 7'h24; 4'd3: seg = 7'h30;
      4'd4: seg = 7'h19; 4'd5: seg = 7'h12; 4'd6: seg = 7'h02; 4'd7: seg = 7'h78;
      4'd8: seg = 7'h00; 4'd9: seg = 7'h10; 4'd14: seg = 7'h06; default: seg = 7'h7F;
    endcase
  endfunction

  // ---------------- scanner / debounce ----------------
  logic [SW-1:0] r_scnt;
  logic [1:0]    r_cidx;
  logic [3:0]    r_fil;
  logic          r_pass_v, r_last_v, r_held, r_evt;
  logic [3:0]    r_pass_key, r_last_key, r_evt_key;
  logic [DW-1:0] r_deb;
  logic          w_stick, w_hit, w_res_v, w_same;
  logic [1:0]    w_row;
  logic [3:0]    w_key, w_res_key;
  logic [DW-1:0] w_deb_n;

  // Lowest low row in the active column; a pass result is the first column hit
  always_comb begin
    w_stick   = (r_scnt == SW'(SCAN_DIV - 1));
    w_hit     = (r_fil != 4'hF);
    w_row     = !r_fil[0] ? 2'd0 : !r_fil[1] ? 2'd1 : !r_fil[2] ? 2'd2 : 2'd3;
    w_key     = key_code(w_row, r_cidx);
    w_res_v   = r_pass_v | w_hit;
    w_res_key = r_pass_v ? r_pass_key : w_key;
    w_same    = (w_res_v == r_last_v) && (!w_res_v || (w_res_key == r_last_key));
    w_deb_n   = !w_same ? DW'(1) : (r_deb == DEB) ? DEB : r_deb + DW'(1);
  end

  // Column rotation, per-pass key capture and press/release debounce
  always_ff @(posedge clk) begin
    if (rst) begin
      r_scnt <= '0; r_cidx <= '0; r_fil <= 4'hF;
      r_pass_v <= 1'b0; r_pass_key <= '0; r_last_v <= 1'b0; r_last_key <= '0;
      r_deb <= '0; r_held <= 1'b0; r_evt <= 1'b0; r_evt_key <= '0;
    end else begin
      r_fil <= bus.fil;
      r_evt <= 1'b0;
      if (w_stick) begin
        r_scnt <= '0;
        r_cidx <= r_cidx + 2'd1;
        if (r_cidx != 2'd3) begin
          if (w_hit && !r_pass_v) begin
            r_pass_v   <= 1'b1;
            r_pass_key <= w_key;
          end
        end else begin
          r_pass_v   <= 1'b0;
          r_last_v   <= w_res_v;
          r_last_key <= w_res_key;
          r_deb      <= w_deb_n;
          if (!r_held && w_res_v && w_deb_n == DEB) begin
            r_evt     <= 1'b1;
            r_evt_key <= w_res_key;
            r_held    <= 1'b1;
          end else if (r_held && !w_res_v && w_deb_n == DEB) begin
            r_held <= 1'b0;
          end
        end
      end else begin
        r_scnt <= r_scnt + SW'(1);
      end
    end
  end

  assign bus.col = ~(4'b0001 << r_cidx);

  // ---------------- entry FSM + divider ----------------
  state_t      r_state, w_state_n;
  logic [3:0]  r_a_t, r_a_u, r_b_t, r_b_u;
  logic        r_a_tv, r_a_uv, r_b_tv, r_b_uv;
  logic [6:0]  r_a_bin, r_b_bin, r_q, r_r, r_rem, r_quo;
  logic [2:0]  r_dcnt;
  logic        r_done;
  logic        w_is_dig, w_is_clr, w_qbit;
  logic [6:0]  w_dig7, w_d10, w_sub, w_rem_n;
  logic [7:0]  w_sh;

  always_comb begin
    w_is_dig = r_evt && (r_evt_key <= 4'd9);
    w_is_clr = r_evt && (r_evt_key == KEY_STAR);
    w_dig7   = {3'b000, r_evt_key};
    w_d10    = (w_dig7 << 3) + (w_dig7 << 1);
    // remainder stays below B, so 7-bit wrap-around subtraction is exact
    w_sh     = {r_rem, r_quo[6]};
    w_qbit   = (w_sh >= {1'b0, r_b_bin});
    w_sub    = w_sh[6:0] - r_b_bin;
    w_rem_n  = w_qbit ? w_sub : w_sh[6:0];
  end

  // Next-state: two digits per operand, fixed 7-step divide, '*' always clears
  always_comb begin
    w_state_n = r_state;
    case (r_state)
      ENTER_A: if (w_is_dig && r_a_tv) w_state_n = ENTER_B;
      ENTER_B: if (w_is_dig && r_b_tv) w_state_n = DIVIDE;
      DIVIDE:  if (r_dcnt == 3'd6)     w_state_n = SHOW;
      SHOW:    if (w_is_dig)           w_state_n = ENTER_A;
      default: w_state_n = ENTER_A;
    endcase
    if (w_is_clr) w_state_n = ENTER_A;
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= ENTER_A;
    else     r_state <= w_state_n;
  end

  // Operand entry, restoring division steps and result capture
  always_ff @(posedge clk) begin
    if (rst || w_is_clr) begin
      r_a_t <= '0; r_a_u <= '0; r_b_t <= '0; r_b_u <= '0;
      r_a_tv <= 1'b0; r_a_uv <= 1'b0; r_b_tv <= 1'b0; r_b_uv <= 1'b0;
      r_a_bin <= '0; r_b_bin <= '0; r_q <= '0; r_r <= '0;
      r_rem <= '0; r_quo <= '0; r_dcnt <= '0; r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ENTER_A: if (w_is_dig) begin
          if (!r_a_tv) begin r_a_t <= r_evt_key; r_a_tv <= 1'b1; r_a_bin <= w_d10; end
          else begin r_a_u <= r_evt_key; r_a_uv <= 1'b1; r_a_bin <= r_a_bin + w_dig7; end
        end
        ENTER_B: if (w_is_dig) begin
          if (!r_b_tv) begin r_b_t <= r_evt_key; r_b_tv <= 1'b1; r_b_bin <= w_d10; end
          else begin
            r_b_u <= r_evt_key; r_b_uv <= 1'b1; r_b_bin <= r_b_bin + w_dig7;
            r_rem <= '0; r_quo <= r_a_bin; r_dcnt <= '0;
          end
        end
        DIVIDE: begin
          r_rem  <= w_rem_n;
          r_quo  <= {r_quo[5:0], w_qbit};
          r_dcnt <= r_dcnt + 3'd1;
          if (r_dcnt == 3'd6) begin
            r_done <= 1'b1;
            if (r_b_bin == '0) begin r_q <= 7'h7F; r_r <= r_a_bin; end
            else begin r_q <= {r_quo[5:0], w_qbit}; r_r <= w_rem_n; end
          end
        end
        SHOW: if (w_is_dig) begin
          r_a_t <= r_evt_key; r_a_tv <= 1'b1; r_a_uv <= 1'b0;
          r_b_tv <= 1'b0; r_b_uv <= 1'b0;
          r_a_bin <= w_d10; r_b_bin <= '0; r_q <= '0; r_r <= '0;
        end
        default: ;
      endcase
    end
  end

  assign bus.A_bin_debug    = {1'b0, r_a_bin};
  assign bus.B_bin_debug    = {1'b0, r_b_bin};
  assign bus.Q_debug        = r_q;
  assign bus.R_debug        = r_r;
  assign bus.div_done_debug = r_done;

  // ---------------- display ----------------
  logic [RW-1:0] r_rcnt;
  logic [1:0]    r_ridx;
  logic          r_on;
  logic [3:0]    r_anodo;
  logic [6:0]    r_seven;
  logic [3:0]    w_code, w_qt, w_qu, w_rt, w_ru;

  // Pick the digit code for the current position (0 = leftmost)
  always_comb begin
    w_qt = 4'(r_q / 7'd10); w_qu = 4'(r_q % 7'd10);
    w_rt = 4'(r_r / 7'd10); w_ru = 4'(r_r % 7'd10);
    w_code = C_BLANK;
    if (r_state == ENTER_A || r_state == ENTER_B) begin
      case (r_ridx)
        2'd0:    w_code = r_a_tv ? r_a_t : C_BLANK;
        2'd1:    w_code = r_a_uv ? r_a_u : C_BLANK;
        2'd2:    w_code = r_b_tv ? r_b_t : C_BLANK;
        default: w_code = r_b_uv ? r_b_u : C_BLANK;
      endcase
    end else if (r_q == 7'h7F) begin
      w_code = C_E;
    end else begin
      case (r_ridx)
        2'd0:    w_code = w_qt;
        2'd1:    w_code = w_qu;
        2'd2:    w_code = w_rt;
        default: w_code = w_ru;
      endcase
    end
  end

  // Digit multiplexing; all digits dark until the first refresh step
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rcnt <= '0; r_ridx <= '0; r_on <= 1'b0; r_anodo <= 4'hF; r_seven <= 7'h7F;
    end else begin
      if (r_rcnt == RW'(REFRESH_DIV - 1)) begin
        r_rcnt <= '0;
        r_on   <= 1'b1;
        if (r_on) r_ridx <= r_ridx + 2'd1;
      end else begin
        r_rcnt <= r_rcnt + RW'(1);
      end
      r_anodo <= r_on ? ~(4'b1000 >> r_ridx) : 4'hF;
      r_seven <= r_on ? seg(w_code) : 7'h7F;
    end
  end

  assign bus.anodo = r_anodo;
  assign bus.seven = r_seven;
endmodule

// File: tb/tb_keypad_divider_display.sv
// Bench for keypad_divider_display: keypad model driven from col, expected
// quotient/remainder pairs queued at entry and popped on each done pulse.
module tb_keypad_divider_display;
  localparam int SCAN_DIV = 4, DEBOUNCE_CNT = 2, REFRESH_DIV = 3;
  localparam int PASS = 4 * SCAN_DIV;
  localparam int HOLD = (DEBOUNCE_CNT + 3) * PASS;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  keypad_divider_display_if bus();

  keypad_divider_display #(
    .SCAN_DIV(SCAN_DIV), .DEBOUNCE_CNT(DEBOUNCE_CNT), .REFRESH_DIV(REFRESH_DIV)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  typedef struct packed { logic [6:0] q; logic [6:0] r; } exp_t;
  exp_t sb[$];
  int checks = 0, errors = 0, done_cnt = 0;

  logic kdown = 1'b0;
  int   kr = 0, kc = 0;

  // Keypad matrix: the pressed key pulls its row low while its column is scanned
  always_comb begin
    bus.fil = 4'hF;
    if (kdown && bus.col[kc] == 1'b0) bus.fil[kr] = 1'b0;
  end

  // Scoreboard: every done pulse must match the oldest queued expectation
  always @(negedge clk) begin
    if (bus.div_done_debug) begin
      exp_t e;
      done_cnt++;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done: got Q=%0d R=%0d, expected no pulse", bus.Q_debug, bus.R_debug);
      end else begin
        e = sb.pop_front();
        if ({bus.Q_debug, bus.R_debug} !== {e.q, e.r}) begin
          errors++;
          $display("FAIL div_result: got Q=%0d R=%0d, expected Q=%0d R=%0d",
                   bus.Q_debug, bus.R_debug, e.q, e.r);
        end
      end
    end
  end

  // codes: 0-9 digits, 10-13 = A-D, 14 = '*', 15 = '#'
  function automatic void key_pos(input int code, output int r, output int c);
    case (code)
      1: begin r = 0; c = 0; end  2: begin r = 0; c = 1; end  3: begin r = 0; c = 2; end
      10: begin r = 0; c = 3; end 4: begin r = 1; c = 0; end  5: begin r = 1; c = 1; end
      6: begin r = 1; c = 2; end  11: begin r = 1; c = 3; end 7: begin r = 2; c = 0; end
      8: begin r = 2; c = 1; end  9: begin r = 2; c = 2; end  12: begin r = 2; c = 3; end
      14: begin r = 3; c = 0; end 0: begin r = 3; c = 1; end  15: begin r = 3; c = 2; end
      default: begin r = 3; c = 3; end
    endcase
  endfunction

  function automatic logic [6:0] exp_seg(input int d);
    case (d)
      0: exp_seg = 7'h40; 1: exp_seg = 7'h79; 2: exp_seg = 7'h24; 3: exp_seg = 7'h30;
      4: exp_seg = 7'h19; 5: exp_seg = 7'h12; 6: exp_seg = 7'h02; 7: exp_seg = 7'h78;
      8: exp_seg = 7'h00; 9: exp_seg = 7'h10; 14: exp_seg = 7'h06; default: exp_seg = 7'h7F;
    endcase
  endfunction

  task automatic key_down(input int code);
    key_pos(code, kr, kc);
    kdown = 1'b1;
  endtask

  task automatic press_key(input int code, input int hold_cycles = HOLD);
    key_down(code);
    repeat (hold_cycles) @(negedge clk);
    kdown = 1'b0;
    repeat (HOLD) @(negedge clk);
  endtask

  task automatic enter4(input int d0, input int d1, input int d2, input int d3);
    press_key(d0); press_key(d1); press_key(d2); press_key(d3);
  endtask

  // Watch the four digit slots for a while; digits given left to right (15 = blank, 14 = E)
  task automatic check_disp(input string name, input int d3, input int d2, input int d1, input int d0);
    logic [3:0][6:0] got;
    logic [3:0][6:0] exp;
    int bad;
    got = 'x;
    bad = 0;
    exp = {exp_seg(d3), exp_seg(d2), exp_seg(d1), exp_seg(d0)};
    repeat (10 * REFRESH_DIV) begin
      @(negedge clk);
      case (bus.anodo)
        4'b0111: got[3] = bus.seven;
        4'b1011: got[2] = bus.seven;
        4'b1101: got[1] = bus.seven;
        4'b1110: got[0] = bus.seven;
        4'b1111: ;
        default: bad++;
      endcase
    end
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL disp_%s: got %h, expected %h", name, got, exp);
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL anodo_onecold_%s: got %0d bad patterns, expected 0", name, bad);
    end
  endtask

  task automatic check_reset_outputs(input string name);
    checks++;
    if ({bus.A_bin_debug, bus.B_bin_debug, bus.Q_debug, bus.R_debug, bus.div_done_debug}
        !== {8'd0, 8'd0, 7'd0, 7'd0, 1'b0}) begin
      errors++;
      $display("FAIL %s_regs: got A=%0d B=%0d Q=%0d R=%0d done=%b, expected all 0", name,
               bus.A_bin_debug, bus.B_bin_debug, bus.Q_debug, bus.R_debug, bus.div_done_debug);
    end
    checks++;
    if ({bus.col, bus.anodo, bus.seven} !== {4'b1110, 4'hF, 7'h7F}) begin
      errors++;
      $display("FAIL %s_io: got col=%b anodo=%b seven=%h, expected 1110 1111 7f", name,
               bus.col, bus.anodo, bus.seven);
    end
  endtask

  task automatic check_ab(input string name, input int a, input int b);
    checks++;
    if (bus.A_bin_debug !== 8'(a) || bus.B_bin_debug !== 8'(b)) begin
      errors++;
      $display("FAIL %s: got A=%0d B=%0d, expected A=%0d B=%0d", name,
               bus.A_bin_debug, bus.B_bin_debug, a, b);
    end
  endtask

  task automatic check_done_cnt(input string name, input int exp);
    checks++;
    if (done_cnt !== exp) begin
      errors++;
      $display("FAIL %s: got %0d done pulses, expected %0d", name, done_cnt, exp);
    end
  endtask

  task automatic test_reset();
    logic [3:0] exp_col [4];
    logic [3:0] prev;
    int k;
    exp_col = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    prev = bus.col;
    for (int i = 1; i < 4; i++) begin
      k = 0;
      while (bus.col === prev && k < 3 * SCAN_DIV) begin @(negedge clk); k++; end
      checks++;
      if (bus.col !== exp_col[i]) begin
        errors++;
        $display("FAIL col_step%0d: got %b, expected %b", i, bus.col, exp_col[i]);
      end
      prev = bus.col;
    end
    check_disp("reset_blank", 15, 15, 15, 15);
  endtask

  task automatic test_divide();
    int k, base;
    base = done_cnt;
    press_key(4); press_key(5);
    check_ab("a_45", 45, 0);
    press_key(0);
    sb.push_back('{q: 7'd6, r: 7'd3});
    key_down(7);
    k = 0;
    while (bus.B_bin_debug !== 8'd7 && k < HOLD) begin @(negedge clk); k++; end
    checks++;
    if (bus.B_bin_debug !== 8'd7) begin
      errors++;
      $display("FAIL b_7: got B=%0d, expected 7", bus.B_bin_debug);
    end
    k = 0;
    while (bus.div_done_debug !== 1'b1 && k < 40) begin @(negedge clk); k++; end
    checks++;
    if (k !== 7) begin
      errors++;
      $display("FAIL done_latency: got %0d cycles, expected 7", k);
    end
    repeat (HOLD) @(negedge clk);
    kdown = 1'b0;
    repeat (HOLD) @(negedge clk);
    check_done_cnt("done_45_7", base + 1);
    check_disp("0603", 0, 6, 0, 3);

    sb.push_back('{q: 7'd99, r: 7'd0});
    enter4(9, 9, 0, 1);
    check_done_cnt("done_99_1", base + 2);
    check_disp("9900", 9, 9, 0, 0);

    sb.push_back('{q: 7'd0, r: 7'd5});
    enter4(0, 5, 1, 2);
    check_done_cnt("done_5_12", base + 3);
    check_disp("0005", 0, 0, 0, 5);
  endtask

  task automatic test_div_zero();
    int base;
    base = done_cnt;
    sb.push_back('{q: 7'd127, r: 7'd12});
    enter4(1, 2, 0, 0);
    check_done_cnt("done_div0", base + 1);
    checks++;
    if (bus.Q_debug !== 7'd127 || bus.R_debug !== 7'd12) begin
      errors++;
      $display("FAIL div0_hold: got Q=%0d R=%0d, expected Q=127 R=12", bus.Q_debug, bus.R_debug);
    end
    check_disp("EEEE", 14, 14, 14, 14);
  endtask

  task automatic test_debounce_ignore();
    int base;
    base = done_cnt;
    press_key(4);
    press_key(5, 12 * PASS);
    check_ab("hold_one_event", 45, 0);
    check_disp("45__", 4, 5, 15, 15);
    press_key(10); press_key(15); press_key(13);
    check_ab("ignored_keys", 45, 0);
    press_key(1);
    press_key(14);
    check_ab("star_clear", 0, 0);
    checks++;
    if (bus.Q_debug !== 7'd0 || bus.R_debug !== 7'd0) begin
      errors++;
      $display("FAIL star_qr: got Q=%0d R=%0d, expected 0 0", bus.Q_debug, bus.R_debug);
    end
    check_disp("star_blank", 15, 15, 15, 15);
    check_done_cnt("no_done_entry", base);
  endtask

  task automatic test_reset_during_divide();
    int k, base;
    base = done_cnt;
    press_key(5); press_key(0); press_key(0);
    key_down(3);
    k = 0;
    while (bus.B_bin_debug !== 8'd3 && k < HOLD) begin @(negedge clk); k++; end
    checks++;
    if (bus.B_bin_debug !== 8'd3) begin
      errors++;
      $display("FAIL b_3: got B=%0d, expected 3", bus.B_bin_debug);
    end
    kdown = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("mid_div_reset");
    @(negedge clk);
    rst = 1'b0;
    repeat (HOLD) @(negedge clk);
    check_done_cnt("no_done_after_rst", base);
    sb.push_back('{q: 7'd42, r: 7'd0});
    enter4(8, 4, 0, 2);
    check_done_cnt("done_84_2", base + 1);
    check_disp("4200", 4, 2, 0, 0);
  endtask

  initial begin
    test_reset();
    test_divide();
    test_div_zero();
    test_debounce_ignore();
    test_reset_during_divide();
    checks++;
    if (sb.size() !== 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/keypad_divider_display.md
Name: keypad_divider_display

Overview:
- Top-level of a keypad-driven 2-digit decimal divider for a 4-digit multiplexed seven-segment board.
- Scans a 4x4 matrix keypad and collects two decimal digits for dividend A, then two for divisor B.
- Computes Q = A / B and R = A mod B with a sequential restoring divider and displays Q and R.
- Exposes binary operands, results and a done strobe as debug ports for verification.

Parameters:
- SCAN_DIV, 50000: clk cycles per keypad column step.
- DEBOUNCE_CNT, 4: consecutive identical scan samples required to accept a press or a release.
- REFRESH_DIV, 50000: clk cycles per display digit step.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- fil  in  4  keypad rows, active-low; 4'hF means no key.
- col  out  4  keypad columns, one-cold scan.
- anodo  out  4  digit enables, active-low; bit3 is the leftmost digit.
- seven  out  7  segments {g,f,e,d,c,b,a}, active-low.
- A_bin_debug  out  8  binary dividend (0..99).
- B_bin_debug  out  8  binary divisor (0..99).
- Q_debug  out  7  quotient.
- R_debug  out  7  remainder.
- div_done_debug  out  1  one-cycle pulse when Q and R become valid.

Behaviour:
- Reset values: col=4'b1110, anodo=4'hF, seven=7'h7F, A/B/Q/R=0, div_done_debug=0, FSM=ENTER_A, all digit registers blank.
- Scanner: every SCAN_DIV cycles, rotate the zero in col through 1110, 1101, 1011, 0111.
- A key is the (active column, lowest-index low row) pair.
- Keymap, rows 0..3 by cols 0..3: 1 2 3 A / 4 5 6 B / 7 8 9 C / * 0 # D.
- A key event is accepted after DEBOUNCE_CNT consecutive column passes that see the same key.
- Exactly one event is generated per press. The next event requires all rows high for DEBOUNCE_CNT full scan passes.
- Simultaneous keys: the lowest row wins in the current column. Other columns are ignored until release.
- Key classes: digits 0-9 are data. '*' is clear: returns to ENTER_A and blanks A, B, Q and R. A, B, C, D and '#' are ignored.
- FSM ENTER_A: first digit becomes the tens digit, second the units digit. A_bin = tens*10 + units. Go to ENTER_B.
- FSM ENTER_B: same two-digit entry into B_bin. On the second digit go to DIVIDE; the divider starts on the next cycle.
- FSM DIVIDE: restoring division over 7 quotient bits, MSB first, one bit per clk.
  - Work on A[6:0] and B[6:0].
  - Exactly 7 cycles after entering DIVIDE, load Q and R, assert div_done_debug for 1 cycle, and go to SHOW.
  - Digit keys are ignored while in DIVIDE.
- Divide by zero (B=0): Q=7'h7F, R=A[6:0]. div_done_debug still pulses with the same latency. The display shows "EE" in both the Q and R positions.
- FSM SHOW: Q and R are held. A digit key starts a new entry (it becomes the A tens digit, Q/R are cleared, go to ENTER_A). '*' clears.
- Debug ports always reflect the current A_bin, B_bin, Q and R registers. Bits [7] of A and B are always 0.
- Display: every REFRESH_DIV cycles, advance one digit, exactly one anodo bit low.
  - In ENTER_A/ENTER_B show A tens, A units, B tens, B units from left to right. Unentered digits are blank (seven=7'h7F).
  - In DIVIDE/SHOW show Q tens, Q units, R tens, R units. Q and R are at most 99.
- Segment encoding, active-low: 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10, E=06, blank=7F.
- rst asserted mid-operation (including during DIVIDE) aborts everything to the reset state on the next edge. No done pulse is produced.

Test Plan:
- Reset, no keys: A=B=Q=R=0, done=0, col cycles 1110 to 1101 to 1011 to 0111, all displayed digits blank.
- Keys 4,5,0,7 (keypad model drives fil from col): A_bin_debug=45, B_bin_debug=7; 7 cycles later a single done pulse with Q=6, R=3; display shows "0603".
- Keys 9,9,0,1 gives Q=99, R=0. Keys 0,5,1,2 gives Q=0, R=5.
- Keys 1,2,0,0 (divide by zero): done pulses, Q=127, R=12, display shows "EEEE".
- Key 4, then hold key 5 for many scan periods: one event only, A=45. Press A, '#', D between digits: no effect. Press '*' after one B digit: returns to ENTER_A with A and B blank.
- Assert rst during DIVIDE: no done pulse, all outputs return to reset values; the next entry of 8,4,0,2 gives Q=42, R=0.
